mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 enable  in  1  start pulse; samples all exec-side inputs.
REQ-005 memread, memwrite  in  1 each  load / store request from exec.
REQ-006 regwrite_in  in  1; rd_in  in  6  writeback control from exec.
REQ-007 funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 aluresult  in  32  byte address.
REQ-009 result  in  32  non-memory writeback value.
REQ-010 rdata1  in  32  store data.
REQ-011 mem_req, mem_we  out  1 each  memory request / write enable.
REQ-012 mem_addr  out  32  word address, aluresult with bits [1:0] = 0.
REQ-013 mem_wdata  out  32; mem_wstrb  out  4  store data and byte lanes.
REQ-014 mem_ack  in  1; mem_rdata  in  32  memory acknowledge and read data.
REQ-015 fin, regwrite, misaligned  out  1 each; rd  out  6; wbdata  out  32  writeback side.

Function
REQ-016 States SHALL be IDLE, REQ, DONE; all outputs SHALL be registered.
REQ-017 IDLE + enable: latch all inputs; next state SHALL be:
- DONE if memread=0 and memwrite=0, or if the access is misaligned;
- REQ otherwise.
REQ-018 Misaligned cases:
- H/HU with addr[0]=1;
- W with addr[1:0]≠0;
- B/BU never misaligned.
REQ-019 memread=memwrite=1 SHALL be treated as a load.
REQ-020 Reserved funct3 codes SHALL be treated as W.
REQ-021 REQ: mem_req=1 with mem_addr, mem_we, mem_wdata and mem_wstrb stable until the edge where mem_ack=1 is sampled; the state SHALL then go to DONE.
REQ-022 mem_ack SHALL be ignored outside REQ.
REQ-023 Store lanes:
- SB: mem_wstrb=0001<<addr[1:0], mem_wdata=rdata1[7:0] replicated ×4;
- SH: mem_wstrb=0011<<addr[1:0], mem_wdata=rdata1[15:0] replicated ×2;
- SW: mem_wstrb=1111, mem_wdata=rdata1.
REQ-024 On loads, mem_we=0 and mem_wstrb=0000.
REQ-025 Load data SHALL be captured from mem_rdata on the ack edge.
- Byte select: addr[1:0]; half select: addr[1].
- B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-026 DONE: fin=1 for exactly one cycle; the state SHALL return to IDLE on the next edge.
REQ-027 Values presented during the DONE cycle:
- regwrite=regwrite_in, or 0 if store or misaligned;
- rd=rd_in;
- wbdata = load data, or result when no memory op;
- misaligned=1 only for a misaligned access.
REQ-028 regwrite, fin and misaligned SHALL be 0 outside DONE; rd and wbdata SHALL hold until the next DONE.
REQ-029 Latency:
- no-memory or misaligned op: enable at cycle T -> fin at T+1;
- memory op: mem_req from T+1, ack at T+1+k (k≥0) -> fin at T+2+k.
REQ-030 enable SHALL be ignored in REQ and DONE, with no re-latch.
REQ-031 Misaligned accesses SHALL never assert mem_req.

Reset
REQ-032 rst SHALL force IDLE and set mem_req, mem_we, mem_wstrb, fin, regwrite, misaligned, rd, wbdata and mem_addr to 0 on the next edge, from any state including mid-REQ.
REQ-033 rst SHALL take priority over enable and mem_ack in the same cycle.
REQ-034 An ack arriving after reset SHALL produce no fin.

Verification
REQ-035 ALU op: enable, memread=memwrite=0, result=0x12345678, rd_in=5, regwrite_in=1 -> next cycle fin=1, wbdata=0x12345678, rd=5, regwrite=1; mem_req never 1.
REQ-036 LB: addr=0x103, ack 3 cycles after mem_req, mem_rdata=0x80FF7F01 -> mem_addr=0x100, fin one cycle after ack, wbdata=0xFFFFFF80.
REQ-037 LHU: addr=0x102, mem_rdata=0x80011234 -> wbdata=0x00008001; LH at the same address -> wbdata=0xFFFF8001.
REQ-038 SB: addr=0x201, rdata1=0x000000AB -> mem_we=1, mem_wstrb=0010, mem_wdata=0xABABABAB, regwrite=0 at fin.
REQ-039 LW: addr=0x202 -> no mem_req, fin next cycle, misaligned=1, regwrite=0.
REQ-040 rst asserted while in REQ, then mem_ack pulsed -> mem_req=0 after the reset edge, fin stays 0, all outputs 0; a following ALU op completes normally.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: issues one load/store per enable pulse, aligns store lanes,
// extracts and extends load data, and presents a single-cycle writeback result.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        regwrite_in,
   input  logic [5:0]  rd_in,
   input  logic [2:0]  funct3,
   input  logic [31:0] aluresult,
   input  logic [31:0] result,
   input  logic [31:0] rdata1,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        fin,
   output logic        regwrite,
   output logic        misaligned,
   output logic [5:0]  rd,
   output logic [31:0] wbdata
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q;
   logic [1:0]  size_q;
   logic        uns_q, store_q, rw_q;
   logic [1:0]  lo_q;
   logic [5:0]  rd_q;

   logic        mem_req_q, mem_we_q, fin_q, regwrite_q, misaligned_q;
   logic [31:0] mem_addr_q, mem_wdata_q, wbdata_q;
   logic [3:0]  mem_wstrb_q;
   logic [5:0]  rd_out_q;

   // size code: 0 byte, 1 half, 2 word (reserved funct3 codes fall into word)
   logic [1:0]  size_d;
   logic        is_mem_d, store_d, mis_d;
   logic [3:0]  wstrb_d;
   logic [31:0] wdata_d, load_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      size_d   = 2'd2;
      if (funct3[1:0] == 2'b00) size_d = 2'd0;
      if (funct3[1:0] == 2'b01) size_d = 2'd1;
      is_mem_d = memread | memwrite;
      store_d  = memwrite & ~memread;
      mis_d    = is_mem_d & (((size_d == 2'd1) & aluresult[0]) |
                             ((size_d == 2'd2) & (|aluresult[1:0])));
      wstrb_d  = 4'b0000;
      wdata_d  = 32'h0;
      if (store_d) begin
         case (size_d)
            2'd0: begin
               wstrb_d = 4'b0001 << aluresult[1:0];
               wdata_d = {4{rdata1[7:0]}};
            end
            2'd1: begin
               wstrb_d = 4'b0011 << aluresult[1:0];
               wdata_d = {2{rdata1[15:0]}};
            end
            default: begin
               wstrb_d = 4'b1111;
               wdata_d = rdata1;
            end
         endcase
      end
   end

   always_comb begin
      byte_sel = mem_rdata[{lo_q, 3'b000} +: 8];
      half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'd0:    load_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'd1:    load_d = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_d = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         store_q      <= 1'b0;
         rw_q         <= 1'b0;
         lo_q         <= 2'd0;
         rd_q         <= 6'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_wstrb_q  <= 4'b0000;
         fin_q        <= 1'b0;
         regwrite_q   <= 1'b0;
         misaligned_q <= 1'b0;
         rd_out_q     <= 6'd0;
         wbdata_q     <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (enable) begin
                  size_q  <= size_d;
                  uns_q   <= funct3[2];
                  store_q <= store_d;
                  rw_q    <= regwrite_in;
                  lo_q    <= aluresult[1:0];
                  rd_q    <= rd_in;
                  if (!is_mem_d || mis_d) begin
                     state_q      <= StDone;
                     fin_q        <= 1'b1;
                     regwrite_q   <= regwrite_in & ~store_d & ~mis_d;
                     misaligned_q <= mis_d;
                     rd_out_q     <= rd_in;
                     if (!is_mem_d) wbdata_q <= result;
                  end else begin
                     state_q     <= StReq;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= store_d;
                     mem_addr_q  <= {aluresult[31:2], 2'b00};
                     mem_wdata_q <= wdata_d;
                     mem_wstrb_q <= wstrb_d;
                  end
               end
            end
            StReq: begin
               if (mem_ack) begin
                  state_q     <= StDone;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= 4'b0000;
                  fin_q       <= 1'b1;
                  regwrite_q  <= rw_q & ~store_q;
                  rd_out_q    <= rd_q;
                  if (!store_q) wbdata_q <= load_d;
               end
            end
            StDone: begin
               state_q      <= StIdle;
               fin_q        <= 1'b0;
               regwrite_q   <= 1'b0;
               misaligned_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign fin        = fin_q;
   assign regwrite   = regwrite_q;
   assign misaligned = misaligned_q;
   assign rd         = rd_out_q;
   assign wbdata     = wbdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized operations
// checked against an arithmetic model of the access rules.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst, enable, memread, memwrite, regwrite_in;
   logic [5:0]  rd_in;
   logic [2:0]  funct3;
   logic [31:0] aluresult, result, rdata1;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        fin, regwrite, misaligned;
   logic [5:0]  rd;
   logic [31:0] wbdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .memread     (memread),
      .memwrite    (memwrite),
      .regwrite_in (regwrite_in),
      .rd_in       (rd_in),
      .funct3      (funct3),
      .aluresult   (aluresult),
      .result      (result),
      .rdata1      (rdata1),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .fin         (fin),
      .regwrite    (regwrite),
      .misaligned  (misaligned),
      .rd          (rd),
      .wbdata      (wbdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete operation, with stimulus, memory response and every observable checked.
   task automatic do_op(input string name, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] res, input logic [31:0] wd,
                        input logic [5:0] rdv, input logic rwv, input int k,
                        input logic [31:0] rdat);
      int          sz;
      logic        uns, isload, isstore, ismem, mis, exp_rw, wb_known;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata, exp_addr, mask, v, exp_wb;
      sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      uns      = (f3 == 3'd4 || f3 == 3'd5);
      isload   = mr;
      isstore  = mw && !mr;
      ismem    = mr || mw;
      mis      = ismem && ((addr % sz) != 0);
      exp_rw   = rwv && !isstore && !mis;
      exp_addr = addr - (addr % 4);
      exp_strb = isstore ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'b0000;
      exp_wdata = (sz == 1) ? wd[7:0] * 32'h01010101 :
                  (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
      v    = rdat >> (8 * (addr % 4));
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v    = v & mask;
      if (!uns && sz < 4 && v[8*sz-1]) v = v | ~mask;
      exp_wb   = ismem ? v : res;
      wb_known = !ismem || (isload && !mis);

      @(posedge clk); #1;
      enable = 1'b1; memread = mr; memwrite = mw; funct3 = f3; aluresult = addr;
      result = res; rdata1 = wd; rd_in = rdv; regwrite_in = rwv;
      tick();
      enable = 1'b0; memread = $urandom; memwrite = $urandom; funct3 = $urandom;
      aluresult = $urandom; result = $urandom; rdata1 = $urandom; rd_in = $urandom;
      regwrite_in = $urandom;

      if (ismem && !mis) begin
         for (int i = 0; i <= k; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_wstrb, fin, regwrite} !== {1'b1, isstore, exp_strb, 2'b00}) begin
               failures++;
               $display("FAIL %s req_ctl cyc%0d got=%b exp=%b", name, i,
                        {mem_req, mem_we, mem_wstrb, fin, regwrite},
                        {1'b1, isstore, exp_strb, 2'b00});
            end
            checks++;
            if (mem_addr !== exp_addr || (isstore && mem_wdata !== exp_wdata)) begin
               failures++;
               $display("FAIL %s req_data cyc%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                        name, i, mem_addr, mem_wdata, exp_addr, exp_wdata);
            end
            if (i < k) begin
               enable = $urandom;  // must be ignored while a request is outstanding
               tick();
            end
         end
         enable = 1'b0; mem_ack = 1'b1; mem_rdata = rdat;
         tick();
         mem_ack = 1'b0; mem_rdata = $urandom;
      end

      checks++;
      if ({fin, regwrite, misaligned, mem_req, rd} !== {1'b1, exp_rw, mis, 1'b0, rdv}) begin
         failures++;
         $display("FAIL %s done got fin/rw/mis/req/rd=%b exp=%b", name,
                  {fin, regwrite, misaligned, mem_req, rd}, {1'b1, exp_rw, mis, 1'b0, rdv});
      end
      if (wb_known) begin
         checks++;
         if (wbdata !== exp_wb) begin
            failures++;
            $display("FAIL %s wbdata got=%h exp=%h", name, wbdata, exp_wb);
         end
      end

      // enable during DONE must not start another operation
      enable = 1'b1; memread = 1'b1; funct3 = 3'd2; aluresult = {$urandom} & 32'hFFFF_FFFC;
      tick();
      enable = 1'b0;
      checks++;
      if ({fin, regwrite, misaligned, mem_req, rd} !== {4'b0000, rdv} ||
          (wb_known && wbdata !== exp_wb)) begin
         failures++;
         $display("FAIL %s after_done got fin/rw/mis/req/rd=%b wb=%h exp=%b wb=%h", name,
                  {fin, regwrite, misaligned, mem_req, rd}, wbdata, {4'b0000, rdv}, exp_wb);
      end
      mem_ack = 1'b1;  // stray ack in IDLE
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({fin, mem_req} !== 2'b00) begin
         failures++;
         $display("FAIL %s stray_ack got fin/req=%b exp=00", name, {fin, mem_req});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({mem_req, mem_we, mem_wstrb, fin, regwrite, misaligned, rd, wbdata, mem_addr} !== '0) begin
         failures++;
         $display("FAIL reset outputs got req=%b we=%b strb=%b fin=%b rw=%b mis=%b rd=%h wb=%h addr=%h exp all zero",
                  mem_req, mem_we, mem_wstrb, fin, regwrite, misaligned, rd, wbdata, mem_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      do_op("alu", 1'b0, 1'b0, 3'd2, 32'h0000_0103, 32'h1234_5678, 32'h0, 6'd5, 1'b1, 0, 32'h0);
   endtask

   task automatic test_loads();
      do_op("lb", 1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h0, 6'd7, 1'b1, 3, 32'h80FF_7F01);
      do_op("lhu", 1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h0, 6'd8, 1'b1, 1, 32'h8001_1234);
      do_op("lh", 1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h0, 6'd9, 1'b1, 0, 32'h8001_1234);
      do_op("lw", 1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'h0, 6'd10, 1'b1, 2, 32'hCAFE_F00D);
   endtask

   task automatic test_stores();
      do_op("sb", 1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'h0, 32'h0000_00AB, 6'd3, 1'b1, 1, 32'h0);
      do_op("sh", 1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0, 32'h1234_BEEF, 6'd4, 1'b1, 0, 32'h0);
      do_op("sw", 1'b0, 1'b1, 3'd2, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 6'd4, 1'b1, 2, 32'h0);
   endtask

   task automatic test_misaligned();
      do_op("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_0202, 32'h0, 32'h0, 6'd11, 1'b1, 0, 32'h0);
      do_op("lh_mis", 1'b1, 1'b0, 3'd1, 32'h0000_0101, 32'h0, 32'h0, 6'd12, 1'b1, 0, 32'h0);
      do_op("sw_mis", 1'b0, 1'b1, 3'd7, 32'h0000_0203, 32'h0, 32'h1, 6'd13, 1'b1, 0, 32'h0);
   endtask

   task automatic test_reset_mid_req();
      @(posedge clk); #1;
      enable = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'd2; aluresult = 32'h0000_0500;
      rd_in = 6'd21; regwrite_in = 1'b1;
      tick();
      enable = 1'b0;
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_req pre got req=%b exp=1", mem_req);
      end
      rst = 1'b1; mem_ack = 1'b1; enable = 1'b1;
      tick();
      rst = 1'b0; mem_ack = 1'b0; enable = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_wstrb, fin, regwrite, misaligned, rd, wbdata, mem_addr} !== '0) begin
         failures++;
         $display("FAIL rst_mid_req outputs got req=%b strb=%b fin=%b rd=%h wb=%h addr=%h exp all zero",
                  mem_req, mem_wstrb, fin, rd, wbdata, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({fin, mem_req, regwrite} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_req late_ack cyc%0d got fin/req/rw=%b exp=000", i,
                     {fin, mem_req, regwrite});
         end
         tick();
      end
      do_op("alu_after_rst", 1'b0, 1'b0, 3'd0, 32'h0, 32'hA5A5_0F0F, 32'h0, 6'd33, 1'b1, 0, 32'h0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         do_op("rand", 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
               6'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; memread = 1'b0; memwrite = 1'b0; regwrite_in = 1'b0;
      rd_in = '0; funct3 = '0; aluresult = '0; result = '0; rdata1 = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_alu();
      test_loads();
      test_stores();
      test_misaligned();
      test_reset_mid_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
